cpu_test_ctrl: RTL

- Synthesisable, parametrised test controller for the tiny MIPS CPU + RAM system.
- Replaces fixed-delay reset and fixed-time finish with real sequencing:
  - a programmable CPU reset hold;
  - a cycle watchdog;
  - memory-bus snooping that detects an end-of-test write and reports pass/fail.
- Sits beside the CPU on the memory bus and sees the same adr/writedata/memwrite as the RAM.
- The bench consumes done/pass/timeout instead of a hard $finish time.

---
 rtl/cpu_test_ctrl_pkg.sv | 23 ++
 rtl/sat_counter.sv | 32 +++
 rtl/cpu_test_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_test_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_test_ctrl_pkg
// Shared types and default constants for the CPU test controller.
//   state_t                 : controller state encoding (3 bits)
//   DEFAULT_DONE_ADDR_BIT   : fill bit for the default end-of-test address
//                             (all ones at any address width)
//   DEFAULT_PASS_VALUE      : data value at the end-of-test address that
//                             signals a passing run
// ---------------------------------------------------------------------------
package cpu_test_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam logic DEFAULT_DONE_ADDR_BIT = 1'b1;
  localparam int   DEFAULT_PASS_VALUE    = 1;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-low reset, clears the count
//   clear  : synchronous clear, same effect as reset
//   enable : count up by one this cycle (ignored once saturated)
//   count  : current count value, W bits
// ---------------------------------------------------------------------------
module sat_counter
  import cpu_test_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  // Holding at all-ones keeps a long run from looking like a fresh start.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_test_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_test_ctrl
// Test controller for the tiny MIPS CPU + RAM system. Holds the CPU in reset
// for RESET_CYCLES after controller reset release, then snoops the memory bus
// while the CPU runs. A write to DONE_ADDR ends the test (pass when the data
// equals PASS_VALUE); a watchdog ends it after MAX_CYCLES run cycles.
//
// Optional feature macro: CPU_TEST_CTRL_CHKSUM_EN adds a rolling signature
// of all run-phase writes on output chksum.
//
// Ports:
//   clk            : clock, rising edge
//   reset          : synchronous active-low reset
//   memwrite       : CPU write strobe (snooped)
//   adr            : CPU address, AW bits (snooped)
//   writedata      : CPU write data, DW bits (snooped)
//   cpu_reset      : active-high reset to the CPU
//   groundconstant : constant 0 tie-off
//   done           : test ended by an end-of-test write
//   pass           : end-of-test data matched PASS_VALUE (valid with done)
//   timeout        : watchdog expired
//   cycle_count    : run cycles elapsed, CNT_W bits, saturating
//   write_count    : run-phase write cycles, CNT_W bits, saturating
//   chksum         : (macro only) write signature, DW bits
// ---------------------------------------------------------------------------
module cpu_test_ctrl
  import cpu_test_ctrl_pkg::*;
#(
  parameter int             DW           = 8,
  parameter int             AW           = 8,
  parameter int             RESET_CYCLES = 2,
  parameter int             MAX_CYCLES   = 30,
  parameter int             CNT_W        = 16,
  parameter logic [AW-1:0]  DONE_ADDR    = {AW{DEFAULT_DONE_ADDR_BIT}},
  parameter logic [DW-1:0]  PASS_VALUE   = DW'(DEFAULT_PASS_VALUE),
  parameter int             HALT_ON_DONE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [AW-1:0]    adr,
  input  logic [DW-1:0]    writedata,
  output logic             cpu_reset,
  output logic             groundconstant,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
`ifdef CPU_TEST_CTRL_CHKSUM_EN
  output logic [CNT_W-1:0] write_count,
  output logic [DW-1:0]    chksum
`else
  output logic [CNT_W-1:0] write_count
`endif
);

  // Parameter sanity; 64-bit arithmetic so wide CNT_W cannot overflow.
  generate
    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
      $error("cpu_test_ctrl: RESET_CYCLES must be >= 1");
    end
    if (MAX_CYCLES < 2) begin : g_bad_max_cycles
      $error("cpu_test_ctrl: MAX_CYCLES must be >= 2");
    end
    if (64'(MAX_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_cnt_w
      $error("cpu_test_ctrl: MAX_CYCLES does not fit in CNT_W bits");
    end
  endgenerate

  state_t           state;
  state_t           next_state;
  logic             in_hold;
  logic             in_run;
  logic             end_of_test;
  logic             run_write;
  logic [CNT_W-1:0] hold_count;

  assign in_hold        = (state == ST_HOLD);
  assign in_run         = (state == ST_RUN);
  assign run_write      = in_run && memwrite;
  assign end_of_test    = run_write && (adr == DONE_ADDR);
  assign groundconstant = 1'b0;

  // Hold counter only advances in HOLD and is kept at zero elsewhere, so
  // every entry into HOLD starts a full reset window.
  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_hold),
    .enable (in_hold),
    .count  (hold_count)
  );

  // Counters freeze automatically in terminal states because they are only
  // enabled while running.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (1'b0),
    .enable (in_run),
    .count  (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_write_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (1'b0),
    .enable (run_write),
    .count  (write_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_HOLD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode. Flags come straight from the registered
  // state, so they appear one cycle after the deciding edge. End-of-test is
  // checked before the watchdog so it wins a tie.
  always_comb begin
    next_state = state;
    cpu_reset  = 1'b1;
    done       = 1'b0;
    pass       = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      ST_HOLD: begin
        if (hold_count == CNT_W'(RESET_CYCLES - 1)) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        cpu_reset = 1'b0;
        if (end_of_test) begin
          next_state = (writedata == PASS_VALUE) ? ST_PASS : ST_FAIL;
        end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
          next_state = ST_TIMEOUT;
        end
      end
      ST_PASS: begin
        cpu_reset = (HALT_ON_DONE != 0);
        done      = 1'b1;
        pass      = 1'b1;
      end
      ST_FAIL: begin
        cpu_reset = (HALT_ON_DONE != 0);
        done      = 1'b1;
      end
      ST_TIMEOUT: begin
        cpu_reset = (HALT_ON_DONE != 0);
        timeout   = 1'b1;
      end
      default: begin
        next_state = ST_HOLD;
      end
    endcase
  end

`ifdef CPU_TEST_CTRL_CHKSUM_EN
  logic [DW-1:0] adr_ext;

  generate
    if (AW >= DW) begin : g_adr_trunc
      assign adr_ext = adr[DW-1:0];
    end else begin : g_adr_pad
      assign adr_ext = {{(DW - AW){1'b0}}, adr};
    end
  endgenerate

  // Rotate-left then fold in data and address of every counted write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chksum <= '0;
    end else if (run_write) begin
      chksum <= {chksum[DW-2:0], chksum[DW-1]} ^ writedata ^ adr_ext;
    end
  end
`endif

endmodule
